spi_cmd_master: RTL and testbench

- Byte-level SPI master that drives the spi2gpio slave protocol from an on-chip controller (test harness, or bring-up board talking to a second FPGA).
- Each request is one two-byte frame with spi_fss held low throughout: a command byte {wr, 4'b0, addr[2:0]}, then a data byte.
- The data byte is the write data for writes and 8'h00 for reads. MISO captured during the data byte is returned as o_rdata.
- Mode 0: sclk idles low, MSB first, slave samples MOSI on the sclk rising edge, master samples MISO on the same edge.

---
 rtl/spi_cmd_master.sv | 175 +++++++++++++++++
 tb/tb_spi_cmd_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// Byte-level SPI master (mode 0) issuing two-byte command/data frames to a spi2gpio slave.
// Optional byte-0 dummy check enabled by defining SPI_DUMMY_CHECK_EN (adds o_err).
module spi_cmd_master #(
  parameter int CLK_DIV   = 8,
  parameter int GAP       = 16,
  parameter int FSS_SETUP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_wr,
  input  logic [2:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       spi_clk,
  output logic       spi_fss,
  output logic       spi_out,
`ifdef SPI_DUMMY_CHECK_EN
  output logic       o_err,
`endif
  input  logic       spi_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT0, S_GAP, S_SHIFT1, S_HOLD, S_DONE
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);
  localparam logic [15:0] SETUP_LAST = 16'(FSS_SETUP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      tx_q    <= '0;
      b1_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      tx_q    <= tx_d;
      b1_q    <= b1_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    tx_d    = tx_q;
    b1_d    = b1_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        if (i_start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = {i_wr, 4'b0000, i_addr};
          b1_d    = i_wr ? i_wdata : 8'h00;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SHIFT0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SHIFT0, S_SHIFT1: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else if (!sclk_q) begin
          // Rising edge: slave has held MISO stable since the previous fall.
          cnt_d  = '0;
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], spi_in};
        end else begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          bit_d  = bit_q + 3'd1;
          tx_d   = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            if (state_q == S_SHIFT0) begin
              state_d = S_GAP;
              tx_d    = b1_q;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHIFT1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          rdata_d = rx_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef SPI_DUMMY_CHECK_EN
  logic dummy_bad_q, dummy_bad_d;
  logic err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dummy_bad_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dummy_bad_q <= dummy_bad_d;
      err_q       <= err_d;
    end
  end

  // Byte-0 result is parked until the frame ends so o_err moves with o_done.
  always_comb begin
    dummy_bad_d = dummy_bad_q;
    err_d       = err_q;
    if (state_q == S_IDLE && i_start) err_d = 1'b0;
    if (state_q == S_SHIFT0 && state_d == S_GAP) dummy_bad_d = (rx_q != 8'h5A);
    if (state_q == S_HOLD && state_d == S_DONE) err_d = dummy_bad_q;
  end

  assign o_err = err_q;
`endif

  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);
  assign o_rdata = rdata_q;
  assign spi_clk = sclk_q;
  assign spi_fss = (state_q == S_IDLE) || (state_q == S_DONE);
  assign spi_out = tx_q[7];

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: a MISO slave model plus a bus monitor on the falling clk edge.
module tb_spi_cmd_master;
  localparam int CLK_DIV   = 8;
  localparam int GAP       = 16;
  localparam int FSS_SETUP = 4;
  localparam int LAT       = 1 + 2 * FSS_SETUP + 32 * CLK_DIV + GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_wr = 1'b0;
  logic [2:0] i_addr = 3'd0;
  logic [7:0] i_wdata = 8'h00;
  logic       o_busy, o_done, spi_clk, spi_fss, spi_out;
  logic [7:0] o_rdata;
  logic       spi_in = 1'b0;
`ifdef SPI_DUMMY_CHECK_EN
  logic       o_err;
`endif

  spi_cmd_master #(.CLK_DIV(CLK_DIV), .GAP(GAP), .FSS_SETUP(FSS_SETUP)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
    .spi_clk(spi_clk), .spi_fss(spi_fss), .spi_out(spi_out),
`ifdef SPI_DUMMY_CHECK_EN
    .o_err(o_err),
`endif
    .spi_in(spi_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mosi;
    logic [7:0]  rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0]  slv_r0 = 8'h5A;
  logic [7:0]  slv_r1 = 8'h00;
  logic [15:0] slv_sr = 16'h0;
  logic [15:0] mosi_sh = 16'h0;
  logic        clk_prev = 1'b0, fss_prev = 1'b1, out_prev = 1'b0, busy_prev = 1'b0;
  int cyc = 0, t_start = 0, t_fss_fall = 0, t_fss_rise = -1, t_rise = 0, t_fall = 0;
  int nrise = 0, sclk_bad = 0, mosi_bad = 0;
  int fss_to_rise = -1, gap_meas = -1, hold_meas = -1, fss_hi_len = -1;
  int frames_started = 0, frames_done = 0;

  // Slave model and bus monitor; everything sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      clk_prev = 1'b0; fss_prev = 1'b1; out_prev = 1'b0; busy_prev = 1'b0;
      nrise = 0; spi_in = 1'b0;
    end else begin
      if (o_busy && !busy_prev) t_start = cyc;
      if (!spi_fss && fss_prev) begin
        frames_started++;
        t_fss_fall = cyc;
        if (t_fss_rise >= 0) fss_hi_len = cyc - t_fss_rise;
        nrise = 0; mosi_sh = 16'h0; sclk_bad = 0; mosi_bad = 0;
        slv_sr = {slv_r0, slv_r1};
        spi_in = slv_sr[15];
      end
      if (spi_fss && !fss_prev) begin
        t_fss_rise = cyc;
        hold_meas  = cyc - t_fall;
      end
      if (spi_clk && !clk_prev) begin
        mosi_sh = {mosi_sh[14:0], spi_out};
        if (nrise == 0) fss_to_rise = cyc - t_fss_fall;
        else if (nrise == 8) gap_meas = cyc - t_fall;
        else if (cyc - t_fall != CLK_DIV) sclk_bad++;
        t_rise = cyc;
        nrise++;
      end
      if (!spi_clk && clk_prev) begin
        if (cyc - t_rise != CLK_DIV) sclk_bad++;
        t_fall = cyc;
        slv_sr = {slv_sr[14:0], 1'b0};
        spi_in = slv_sr[15];
      end
      if (spi_clk && clk_prev && spi_out !== out_prev) mosi_bad++;
      if (spi_fss && spi_clk) sclk_bad++;
      if (o_done) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_done: o_done seen at cycle %0d with nothing expected", cyc);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (mosi_sh !== e.mosi) begin
            n_fail++; $display("FAIL mosi_bytes: got %h expected %h", mosi_sh, e.mosi);
          end
          n_checks++;
          if (nrise !== 16) begin
            n_fail++; $display("FAIL sclk_rises: got %0d expected 16", nrise);
          end
          n_checks++;
          if (o_rdata !== e.rdata) begin
            n_fail++; $display("FAIL rdata: got %h expected %h", o_rdata, e.rdata);
          end
          n_checks++;
          if (cyc - t_start + 1 !== LAT) begin
            n_fail++; $display("FAIL latency: got %0d expected %0d", cyc - t_start + 1, LAT);
          end
          n_checks++;
          if (sclk_bad !== 0 || mosi_bad !== 0) begin
            n_fail++; $display("FAIL bit_timing: sclk_bad %0d mosi_bad %0d expected 0/0", sclk_bad, mosi_bad);
          end
`ifdef SPI_DUMMY_CHECK_EN
          n_checks++;
          if (o_err !== e.err) begin
            n_fail++; $display("FAIL o_err: got %b expected %b", o_err, e.err);
          end
`endif
        end
        frames_done++;
      end
      clk_prev = spi_clk; fss_prev = spi_fss; out_prev = spi_out; busy_prev = o_busy;
    end
  end

  task automatic start_frame(input logic wr, input logic [2:0] addr, input logic [7:0] wd,
                             input logic [7:0] r0, input logic [7:0] r1, input logic exp_err);
    exp_t e;
    @(negedge clk);
    slv_r0 = r0; slv_r1 = r1;
    i_wr = wr; i_addr = addr; i_wdata = wd; i_start = 1'b1;
    e.mosi  = {wr, 4'b0000, addr, (wr ? wd : 8'h00)};
    e.rdata = r1;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = frames_done;
    int k = 0;
    while (frames_done == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (frames_done != d0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (spi_fss !== 1'b1) begin n_fail++; $display("FAIL reset_fss: got %b expected 1", spi_fss); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", spi_clk); end
    n_checks++; if (spi_out !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b expected 0", spi_out); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_done); end
    n_checks++; if (o_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", o_rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    bit ok;
    start_frame(1'b1, 3'd1, 8'hA5, 8'h5A, 8'h96, 1'b0);
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL write_timeout: done seen %b expected 1", ok); end
    repeat (20) @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL write_idle_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_rdata !== 8'h96) begin n_fail++; $display("FAIL rdata_hold: got %h expected 96", o_rdata); end
  endtask

  task automatic test_read;
    bit ok;
    start_frame(1'b0, 3'd2, 8'hFF, 8'h5A, 8'h3C, 1'b0);
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_timeout: done seen %b expected 1", ok); end
    n_checks++; if (o_rdata !== 8'h3C) begin n_fail++; $display("FAIL read_rdata: got %h expected 3C", o_rdata); end
  endtask

  task automatic test_timing;
    bit ok;
    start_frame(1'b1, 3'd7, 8'h3C, 8'h5A, 8'hC3, 1'b0);
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timing_timeout: done seen %b expected 1", ok); end
    n_checks++;
    if (fss_to_rise !== FSS_SETUP + CLK_DIV) begin
      n_fail++; $display("FAIL fss_to_first_rise: got %0d expected %0d", fss_to_rise, FSS_SETUP + CLK_DIV);
    end
    // Byte gap plus the low phase of byte 1's first bit.
    n_checks++;
    if (gap_meas !== GAP + CLK_DIV) begin
      n_fail++; $display("FAIL byte_gap: got %0d expected %0d", gap_meas, GAP + CLK_DIV);
    end
    n_checks++;
    if (hold_meas !== FSS_SETUP) begin
      n_fail++; $display("FAIL fss_hold: got %0d expected %0d", hold_meas, FSS_SETUP);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    exp_t e;
    int k = 0;
    int fs0;
    @(negedge clk);
    slv_r0 = 8'h5A; slv_r1 = 8'h69;
    i_wr = 1'b1; i_addr = 3'd5; i_wdata = 8'h5C; i_start = 1'b1;
    e.mosi = 16'h855C; e.rdata = 8'h69; e.err = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    fs0 = frames_started;
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_first_timeout: done seen %b expected 1", ok); end
    while (frames_started < fs0 + 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    i_start = 1'b0;
    n_checks++;
    if (frames_started !== fs0 + 2) begin
      n_fail++; $display("FAIL b2b_restart: frames %0d expected %0d", frames_started - fs0, 2);
    end
    // DONE cycle plus the IDLE cycle that accepts the held start.
    n_checks++;
    if (fss_hi_len !== 2) begin n_fail++; $display("FAIL b2b_fss_high: got %0d expected 2", fss_hi_len); end
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_second_timeout: done seen %b expected 1", ok); end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    int fs0 = frames_started;
    start_frame(1'b0, 3'd3, 8'h00, 8'h5A, 8'hE7, 1'b0);
    repeat (100) @(negedge clk);
    i_wr = 1'b1; i_addr = 3'd4; i_wdata = 8'hF0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_timeout: done seen %b expected 1", ok); end
    repeat (LAT + 20) @(negedge clk);
    n_checks++;
    if (frames_started !== fs0 + 1) begin
      n_fail++; $display("FAIL busy_extra_frame: frames %0d expected 1", frames_started - fs0);
    end
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL busy_sb_left: got %0d expected 0", sb.size()); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int k = 0;
    start_frame(1'b1, 3'd6, 8'h11, 8'h5A, 8'h77, 1'b0);
    repeat (150) @(negedge clk);
    while (spi_clk !== 1'b1 && k < 4 * CLK_DIV) begin
      @(negedge clk);
      k++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (spi_fss !== 1'b1) begin n_fail++; $display("FAIL mid_reset_fss: got %b expected 1", spi_fss); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sclk: got %b expected 0", spi_clk); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_rdata: got %h expected 00", o_rdata); end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(1'b1, 3'd0, 8'hC6, 8'h5A, 8'hE1, 1'b0);
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL post_reset_timeout: done seen %b expected 1", ok); end
  endtask

`ifdef SPI_DUMMY_CHECK_EN
  task automatic test_dummy_check;
    bit ok;
    start_frame(1'b0, 3'd1, 8'h00, 8'h00, 8'h12, 1'b1);
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dummy_bad_timeout: done seen %b expected 1", ok); end
    start_frame(1'b0, 3'd1, 8'h00, 8'h5A, 8'h34, 1'b0);
    wait_done(LAT + 20, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dummy_ok_timeout: done seen %b expected 1", ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timing();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
`ifdef SPI_DUMMY_CHECK_EN
    test_dummy_check();
`endif
    repeat (5) @(negedge clk);
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
